// File: rtl/neuron_tdm_ctrl.sv
// Time-multiplexing controller: steps one shared STDP neuron datapath
// across N virtual neurons per timestep, holding membranes and refractory state.
module neuron_tdm_ctrl #(
   parameter int N      = 4,
   parameter int DP_LAT = 1,
   parameter int REFRAC = 3,
   parameter int REF_W  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [7:0]           in_spikes,
   input  logic                 learn_en,
   input  logic                 clear,
   output logic                 dp_req,
   output logic [$clog2(N)-1:0] dp_sel,
   output logic [7:0]           dp_inputs,
   output logic [7:0]           dp_mem,
   output logic                 dp_learn,
   input  logic [7:0]           dp_sum,
   input  logic                 dp_spike,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N-1:0]         out_spikes
);

   localparam int SEL_W = $clog2(N);
   localparam int CNT_W = $clog2(DP_LAT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t             state, state_nxt;
   logic [7:0]         vec;
   logic [SEL_W-1:0]   idx;
   logic [CNT_W-1:0]   cnt;
   logic               learn_q;
   logic [7:0]         mem  [N];
   logic [REF_W-1:0]   refc [N];

   logic is_ref, last_idx, last_wait, active;

   assign is_ref    = (refc[idx] != '0);
   assign last_idx  = (idx == SEL_W'(N - 1));
   assign last_wait = (state == WAIT) && (cnt == CNT_W'(DP_LAT - 1));
   assign active    = (state == ISSUE) || (state == WAIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!clear && in_valid) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (last_wait) state_nxt = last_idx ? DONE : ISSUE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vec        <= '0;
         idx        <= '0;
         cnt        <= '0;
         learn_q    <= 1'b0;
         out_spikes <= '0;
         for (int i = 0; i < N; i++) begin
            mem[i]  <= '0;
            refc[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (clear) begin
                  for (int i = 0; i < N; i++) begin
                     mem[i]  <= '0;
                     refc[i] <= '0;
                  end
               end else if (in_valid) begin
                  vec        <= in_spikes;
                  idx        <= '0;
                  out_spikes <= '0;
               end
            end
            ISSUE: begin
               cnt     <= '0;
               learn_q <= learn_en & ~is_ref;
            end
            WAIT: begin
               cnt <= cnt + CNT_W'(1);
               if (last_wait) begin
                  // a refractory slot ignores the datapath result entirely
                  if (is_ref) begin
                     mem[idx]  <= '0;
                     refc[idx] <= refc[idx] - REF_W'(1);
                  end else if (dp_spike) begin
                     out_spikes[idx] <= 1'b1;
                     mem[idx]        <= '0;
                     refc[idx]       <= REF_W'(REFRAC);
                  end else begin
                     mem[idx] <= dp_sum;
                  end
                  idx <= last_idx ? '0 : idx + SEL_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state == IDLE) && !clear;
      out_valid = (state == DONE);
      dp_req    = (state == ISSUE);
      dp_sel    = active ? idx : '0;
      dp_mem    = active ? mem[idx] : '0;
      dp_inputs = (active && !is_ref) ? vec : '0;
      dp_learn  = 1'b0;
      if (state == ISSUE)     dp_learn = learn_en & ~is_ref;
      else if (state == WAIT) dp_learn = learn_q;
   end

endmodule

// File: tb/tb_neuron_tdm_ctrl.sv
// Directed bench for neuron_tdm_ctrl with a table-driven datapath stand-in
// and hand-computed membrane/spike expectations per timestep.
module tb_neuron_tdm_ctrl;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [7:0]   in_spikes = '0;
   logic         learn_en = 1'b0;
   logic         clear = 1'b0;
   logic         dp_req;
   logic [1:0]   dp_sel;
   logic [7:0]   dp_inputs;
   logic [7:0]   dp_mem;
   logic         dp_learn;
   logic [7:0]   dp_sum;
   logic         dp_spike;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [N-1:0] out_spikes;

   logic [7:0]   sum_val = '0;
   logic [N-1:0] spike_mask = '0;

   assign dp_sum   = sum_val;
   assign dp_spike = spike_mask[dp_sel];

   neuron_tdm_ctrl #(.N(N), .DP_LAT(1), .REFRAC(3), .REF_W(4)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_spikes(in_spikes),
      .learn_en(learn_en), .clear(clear),
      .dp_req(dp_req), .dp_sel(dp_sel), .dp_inputs(dp_inputs),
      .dp_mem(dp_mem), .dp_learn(dp_learn),
      .dp_sum(dp_sum), .dp_spike(dp_spike),
      .out_valid(out_valid), .out_ready(out_ready), .out_spikes(out_spikes)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   logic [7:0] o_in    [N];
   logic [7:0] o_mem   [N];
   logic       o_learn [N];

   always @(negedge clk) begin
      if (dp_req) begin
         o_in[dp_sel]    = dp_inputs;
         o_mem[dp_sel]   = dp_mem;
         o_learn[dp_sel] = dp_learn;
      end
   end

   task automatic step(input logic [7:0] spk, input logic lrn,
                       input logic [N-1:0] mask, input logic [7:0] sum,
                       input bit clr_mid, input int hold,
                       output logic [N-1:0] outs);
      int cyc;
      logic [N-1:0] snap;
      for (int i = 0; i < N; i++) begin
         o_in[i] = 8'hEE; o_mem[i] = 8'hEE; o_learn[i] = 1'bx;
      end
      in_spikes = spk; learn_en = lrn; spike_mask = mask; sum_val = sum;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_spikes = 8'hFF;
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         clear = clr_mid && (cyc == 3);
      end
      clear = 1'b0;
      chk("latency", cyc, 8);
      snap = out_spikes;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("bp_valid", out_valid, 1);
         chk("bp_spikes", out_spikes, snap);
         chk("bp_in_ready", in_ready, 0);
      end
      outs = out_spikes;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("hs_in_ready", in_ready, 1);
      chk("hs_out_valid", out_valid, 0);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   logic [N-1:0] outs;
   int k;

   initial begin
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dp_req", dp_req, 0);
      chk("rst_out_spikes", out_spikes, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      step(8'hA5, 1'b1, 4'b0000, 8'h10, 0, 0, outs);
      chk("ts1_out", outs, 4'b0000);
      for (int i = 0; i < N; i++) begin
         chk("ts1_in", o_in[i], 8'hA5);
         chk("ts1_learn", o_learn[i], 1);
         chk("ts1_mem", o_mem[i], 8'h00);
      end

      step(8'h3C, 1'b1, 4'b0010, 8'h20, 0, 0, outs);
      chk("ts2_out", outs, 4'b0010);
      for (int i = 0; i < N; i++) chk("ts2_mem", o_mem[i], 8'h10);

      for (int t = 0; t < 3; t++) begin
         step(8'h5A, 1'b1, 4'b0010, 8'h30, 0, 0, outs);
         chk("ref_out", outs, 4'b0000);
         chk("ref_in1", o_in[1], 8'h00);
         chk("ref_learn1", o_learn[1], 0);
         chk("ref_mem1", o_mem[1], 8'h00);
         chk("ref_in0", o_in[0], 8'h5A);
         chk("ref_mem0", o_mem[0], (t == 0) ? 8'h20 : 8'h30);
      end

      step(8'h81, 1'b0, 4'b1000, 8'h40, 0, 0, outs);
      chk("ts6_out", outs, 4'b1000);
      chk("ts6_in1", o_in[1], 8'h81);
      chk("ts6_mem1", o_mem[1], 8'h00);
      chk("ts6_mem0", o_mem[0], 8'h30);
      for (int i = 0; i < N; i++) chk("ts6_learn", o_learn[i], 0);

      step(8'hC3, 1'b1, 4'b0000, 8'h50, 0, 5, outs);
      chk("ts7_out", outs, 4'b0000);
      for (int i = 0; i < 3; i++) chk("ts7_learn", o_learn[i], 1);
      chk("ts7_learn3", o_learn[3], 0);
      chk("ts7_in3", o_in[3], 8'h00);

      clear = 1'b1; in_valid = 1'b1; in_spikes = 8'h77;
      #1;
      chk("clr_in_ready", in_ready, 0);
      @(posedge clk);
      @(negedge clk);
      chk("clr_no_accept", dp_req, 0);
      clear = 1'b0; in_valid = 1'b0;
      @(negedge clk);

      step(8'h11, 1'b1, 4'b0000, 8'h60, 0, 0, outs);
      for (int i = 0; i < N; i++) chk("clr_mem", o_mem[i], 8'h00);
      chk("clr_in3", o_in[3], 8'h11);
      chk("clr_learn3", o_learn[3], 1);

      step(8'h22, 1'b1, 4'b0000, 8'h70, 1, 0, outs);
      for (int i = 0; i < N; i++) chk("wclr_mem", o_mem[i], 8'h60);
      step(8'h33, 1'b1, 4'b0000, 8'h80, 0, 0, outs);
      for (int i = 0; i < N; i++) chk("wclr_mem2", o_mem[i], 8'h70);

      in_spikes = 8'h44; learn_en = 1'b1; spike_mask = 4'b0001;
      sum_val = 8'h90; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      while (!(dp_sel == 2'd2 && !dp_req) && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("mid_reach", k < 20, 1);
      chk("mid_spikes", out_spikes, 4'b0001);
      #2 reset = 1'b1;
      #1;
      chk("mid_dp_req", dp_req, 0);
      chk("mid_dp_sel", dp_sel, 0);
      chk("mid_dp_mem", dp_mem, 0);
      chk("mid_dp_in", dp_inputs, 0);
      chk("mid_dp_learn", dp_learn, 0);
      chk("mid_out_valid", out_valid, 0);
      chk("mid_out_spk", out_spikes, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_in_ready", in_ready, 1);
      chk("post_out_valid", out_valid, 0);
      @(negedge clk);

      step(8'h55, 1'b1, 4'b0000, 8'hA0, 0, 0, outs);
      chk("post_out", outs, 4'b0000);
      chk("post_in0", o_in[0], 8'h55);
      for (int i = 0; i < N; i++) chk("post_mem", o_mem[i], 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
